misc: RTL and testbench



---
 rtl/misc_pkg.sv | 42 ++++
 rtl/misc_data_mem.sv | 27 ++
 rtl/misc.sv | 262 ++++++++++++++++++++++++++
 tb/tb_misc.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/misc_pkg.sv
// misc_pkg: shared constants, FSM state type and LFSR step for the misc
// stream-cipher engine.
package misc_pkg;

  // Memory and frame geometry
  localparam int DM_DEPTH  = 256;
  localparam int MSG_LEN   = 41;
  localparam int FRAME_LEN = 64;
  localparam int NUM_TAPS  = 8;

  // Padding byte; frame bytes outside the message are ASCII space
  localparam logic [7:0] SPACE = 8'h20;

  // Fixed addresses inside the data memory
  localparam logic [7:0] PRE_ADDR  = 8'd41;
  localparam logic [7:0] PTRN_ADDR = 8'd42;
  localparam logic [7:0] INIT_ADDR = 8'd43;
  localparam logic [7:0] OUT_BASE  = 8'd64;

  // Tap candidates, tried in this order when recovering the key
  localparam logic [7:0] TAPS [0:NUM_TAPS-1] = '{
    8'hE1, 8'hD4, 8'hC6, 8'hB8, 8'hB4, 8'hB2, 8'hFA, 8'hF3
  };

  typedef enum logic [3:0] {
    IDLE,
    MODE,
    ENC_LOAD,
    ENC_RUN,
    DEC_SEED,
    DEC_SEARCH,
    DEC_SCAN,
    DEC_WRITE,
    DONE
  } state_t;

  // One LFSR step: shift left, feed back the parity of the tapped bits
  function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] ptrn);
    return {s[6:0], ^(s & ptrn)};
  endfunction

endpackage

// File: rtl/misc_data_mem.sv
// misc_data_mem: 256x8 data memory, combinational read, synchronous write,
// single shared address. The array lives in scope dm1 as DM so it can be
// preloaded hierarchically; reset never touches its contents.
module misc_data_mem
  import misc_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  if (1) begin : dm1
    logic [7:0] DM [0:DM_DEPTH-1];

    // Synchronous write port
    always_ff @(posedge clk) begin
      if (we) begin
        DM[addr] <= wdata;
      end
    end

    assign rdata = DM[addr];
  end

endmodule

// File: rtl/misc.sv
// misc: hardwired LFSR stream-cipher engine.
// DM[43] != 0: encrypt the 41-byte message in DM[0..40] (preamble DM[41],
// taps DM[42], seed DM[43]) into the 64-byte frame at DM[64..127].
// DM[43] == 0: recover the key from the space preamble of DM[64..127],
// decrypt, strip leading spaces and write the plaintext to DM[0..63].
// Build macro MISC_KEY_REPORT_EN: after decrypt also write the match flag,
// recovered taps and seed to DM[253..255].
// Memory is single-ported, so every frame byte takes a read cycle and a
// write cycle (phase 0 / phase 1).
module misc
  import misc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic done
);

`ifdef MISC_KEY_REPORT_EN
  localparam logic [7:0] RPT_BASE = 8'd253;
`endif

  state_t state, nstate;

  // Memory port
  logic       we;
  logic [7:0] addr, wdata, rdata;

  // Datapath registers
  logic [7:0] s;        // running keystream state
  logic [7:0] s0;       // recovered seed (decrypt)
  logic [7:0] ptrn;     // active tap pattern
  logic [7:0] pre_len;  // preamble length (encrypt)
  logic [7:0] byte_q;   // byte fetched in phase 0, written in phase 1
  logic [7:0] ts;       // trial state while testing a tap candidate
  logic [6:0] idx;      // frame / output index
  logic [6:0] f;        // first non-space decrypted index
  logic       phase;
  logic [2:0] cand;
  logic [3:0] k;
`ifdef MISC_KEY_REPORT_EN
  logic       matched;
`endif

  // Derived terms
  logic       enc_in_msg;
  logic [7:0] tnext;
  logic       search_hit;
  logic [7:0] dec_byte;
  logic [6:0] src;
  logic       src_in_frame;
  logic       last_idx;

  misc_data_mem data_mem (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign enc_in_msg   = ({2'b00, idx} >= {1'b0, pre_len}) &&
                        ({2'b00, idx} <  ({1'b0, pre_len} + 9'(MSG_LEN)));
  assign tnext        = lfsr_next(ts, TAPS[cand]);
  assign search_hit   = ((rdata ^ SPACE) == tnext);
  assign dec_byte     = rdata ^ s;
  assign src          = f + idx;
  assign src_in_frame = ~src[6];
  assign last_idx     = (idx == 7'(FRAME_LEN - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      IDLE:       nstate = MODE;
      MODE:       nstate = (rdata != 8'h00) ? ENC_LOAD : DEC_SEED;
      ENC_LOAD:   if (phase) nstate = ENC_RUN;
      ENC_RUN:    if (phase && last_idx) nstate = DONE;
      DEC_SEED:   nstate = DEC_SEARCH;
      DEC_SEARCH: begin
        if ((search_hit && k == 4'd8) ||
            (!search_hit && cand == 3'(NUM_TAPS - 1))) begin
          nstate = DEC_SCAN;
        end
      end
      DEC_SCAN:   if ((dec_byte != SPACE) || last_idx) nstate = DEC_WRITE;
      DEC_WRITE: begin
`ifdef MISC_KEY_REPORT_EN
        if (idx == 7'd66) nstate = DONE;
`else
        if (phase && last_idx) nstate = DONE;
`endif
      end
      DONE:       nstate = DONE;
      default:    nstate = IDLE;
    endcase
  end

  // Output logic: memory port and done
  always_comb begin
    addr  = 8'h00;
    we    = 1'b0;
    wdata = 8'h00;
    done  = 1'b0;
    case (state)
      MODE:       addr = INIT_ADDR;
      ENC_LOAD:   addr = phase ? PTRN_ADDR : PRE_ADDR;
      ENC_RUN: begin
        if (!phase) begin
          addr = {1'b0, idx} - pre_len;
        end else begin
          addr  = OUT_BASE + {1'b0, idx};
          we    = 1'b1;
          wdata = byte_q ^ s;
        end
      end
      DEC_SEED:   addr = OUT_BASE;
      DEC_SEARCH: addr = OUT_BASE + {4'h0, k};
      DEC_SCAN:   addr = OUT_BASE + {1'b0, idx};
      DEC_WRITE: begin
`ifdef MISC_KEY_REPORT_EN
        if (idx[6]) begin
          addr = RPT_BASE + {6'b000000, idx[1:0]};
          we   = 1'b1;
          case (idx[1:0])
            2'd0:    wdata = {7'b0000000, matched};
            2'd1:    wdata = ptrn;
            default: wdata = s0;
          endcase
        end else
`endif
        if (!phase) begin
          addr = OUT_BASE + {1'b0, src};
        end else begin
          addr  = {1'b0, idx};
          we    = 1'b1;
          wdata = byte_q;
        end
      end
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Datapath registers: keystream, key search and frame indexing
  always_ff @(posedge clk) begin
    if (reset) begin
      s       <= 8'h00;
      s0      <= 8'h00;
      ptrn    <= 8'h00;
      pre_len <= 8'h00;
      byte_q  <= 8'h00;
      ts      <= 8'h00;
      idx     <= 7'd0;
      f       <= 7'd0;
      phase   <= 1'b0;
      cand    <= 3'd0;
      k       <= 4'd0;
`ifdef MISC_KEY_REPORT_EN
      matched <= 1'b0;
`endif
    end else begin
      case (state)
        MODE: begin
          s     <= rdata;
          idx   <= 7'd0;
          phase <= 1'b0;
        end
        ENC_LOAD: begin
          if (!phase) pre_len <= rdata;
          else        ptrn    <= rdata;
          phase <= ~phase;
        end
        ENC_RUN: begin
          if (!phase) begin
            byte_q <= enc_in_msg ? rdata : SPACE;
            phase  <= 1'b1;
          end else begin
            s     <= lfsr_next(s, ptrn);
            idx   <= idx + 7'd1;
            phase <= 1'b0;
          end
        end
        DEC_SEED: begin
          s0   <= rdata ^ SPACE;
          ts   <= rdata ^ SPACE;
          cand <= 3'd0;
          k    <= 4'd1;
        end
        DEC_SEARCH: begin
          if (search_hit) begin
            if (k == 4'd8) begin
              ptrn <= TAPS[cand];
              s    <= s0;
              idx  <= 7'd0;
`ifdef MISC_KEY_REPORT_EN
              matched <= 1'b1;
`endif
            end else begin
              ts <= tnext;
              k  <= k + 4'd1;
            end
          end else if (cand == 3'(NUM_TAPS - 1)) begin
            // No candidate reproduced the preamble: fall back to the first
            ptrn <= TAPS[0];
            s    <= s0;
            idx  <= 7'd0;
`ifdef MISC_KEY_REPORT_EN
            matched <= 1'b0;
`endif
          end else begin
            cand <= cand + 3'd1;
            k    <= 4'd1;
            ts   <= s0;
          end
        end
        DEC_SCAN: begin
          // s is left at s_f when the first non-space byte is found
          if (dec_byte != SPACE) begin
            f     <= idx;
            idx   <= 7'd0;
            phase <= 1'b0;
          end else begin
            s <= lfsr_next(s, ptrn);
            if (last_idx) begin
              f     <= 7'(FRAME_LEN);
              idx   <= 7'd0;
              phase <= 1'b0;
            end else begin
              idx <= idx + 7'd1;
            end
          end
        end
        DEC_WRITE: begin
`ifdef MISC_KEY_REPORT_EN
          if (idx[6]) begin
            idx <= idx + 7'd1;
          end else
`endif
          if (!phase) begin
            byte_q <= src_in_frame ? dec_byte : SPACE;
            if (src_in_frame) s <= lfsr_next(s, ptrn);
            phase <= 1'b1;
          end else begin
            idx   <= idx + 7'd1;
            phase <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_misc.sv
`timescale 1ns/1ps
// tb_misc: directed and randomized frames for the misc cipher engine,
// checked against a frame-level reference model.
module tb_misc;

  logic clk;
  logic reset;
  logic done;

  misc dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] img   [0:255];
  logic [7:0] msg_b [0:40];
  logic [7:0] m_ks  [0:63];
  logic [7:0] m_out [0:63];
  logic [7:0] m_tap, m_s0, m_match;
  logic [7:0] taps  [0:7];

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    assert (dut.state === misc_pkg::IDLE) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dut.state, misc_pkg::IDLE);
    end
  endtask

  // Reference model
  function automatic logic [7:0] step(input logic [7:0] s, input logic [7:0] t);
    return {s[6:0], ^(s & t)};
  endfunction

  task automatic gen_ks(input logic [7:0] seed, input logic [7:0] t);
    logic [7:0] s;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      m_ks[i] = s;
      s = step(s, t);
    end
  endtask

  task automatic set_msg(input string str);
    for (int i = 0; i < 41; i++) msg_b[i] = (i < str.len()) ? str[i] : 8'h20;
  endtask

  task automatic model_enc(input int pre, input logic [7:0] t, input logic [7:0] init);
    logic [7:0] p;
    gen_ks(init, t);
    for (int i = 0; i < 64; i++) begin
      p = (i >= pre && i < pre + 41) ? msg_b[i - pre] : 8'h20;
      m_out[i] = p ^ m_ks[i];
    end
  endtask

  task automatic model_dec;
    logic [7:0] s;
    bit found, ok;
    int f;
    m_s0 = img[64] ^ 8'h20;
    m_tap = taps[0];
    m_match = 8'h00;
    found = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (!found) begin
        s = m_s0;
        ok = 1'b1;
        for (int kk = 1; kk <= 8; kk++) begin
          s = step(s, taps[c]);
          if (s != (img[64 + kk] ^ 8'h20)) ok = 1'b0;
        end
        if (ok) begin
          found = 1'b1;
          m_tap = taps[c];
          m_match = 8'h01;
        end
      end
    end
    gen_ks(m_s0, m_tap);
    f = 64;
    for (int i = 63; i >= 0; i--) if ((img[64 + i] ^ m_ks[i]) != 8'h20) f = i;
    for (int j = 0; j < 64; j++)
      m_out[j] = (f + j < 64) ? (img[64 + f + j] ^ m_ks[f + j]) : 8'h20;
  endtask

  // Drivers
  task automatic fill_rand;
    for (int a = 0; a < 256; a++) img[a] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_zero;
    for (int a = 0; a < 256; a++) img[a] = 8'h00;
  endtask

  task automatic setup_enc(input int pre, input logic [7:0] t, input logic [7:0] init);
    fill_rand();
    for (int i = 0; i < 41; i++) img[i] = msg_b[i];
    img[41] = 8'(pre);
    img[42] = t;
    img[43] = init;
    model_enc(pre, t, init);
  endtask

  // Ciphertext from the last model_enc becomes a decrypt image
  task automatic setup_dec;
    fill_zero();
    for (int i = 0; i < 64; i++) img[64 + i] = m_out[i];
  endtask

  task automatic load_dut;
    for (int a = 0; a < 256; a++) dut.data_mem.dm1.DM[a] = img[a];
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check1({tag, "_done"}, done, 1'b1);
  endtask

  task automatic run(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check1({tag, "_rst_done"}, done, 1'b0);
    check_idle({tag, "_rst_state"});
    load_dut();
    @(negedge clk);
    reset = 1'b0;
    wait_done(tag);
  endtask

  // Scoreboard
  task automatic push_model;
    for (int i = 0; i < 64; i++) exp_q.push_back(m_out[i]);
  endtask

  task automatic check_out(input string tag, input int base);
    logic [7:0] e;
    for (int i = 0; i < 64; i++) begin
      e = exp_q.pop_front();
      check8($sformatf("%s[%0d]", tag, i), dut.data_mem.dm1.DM[base + i], e);
    end
  endtask

  task automatic check_report(input string tag);
`ifdef MISC_KEY_REPORT_EN
    check8({tag, "_rpt_match"}, dut.data_mem.dm1.DM[253], m_match);
    check8({tag, "_rpt_tap"},   dut.data_mem.dm1.DM[254], m_tap);
    check8({tag, "_rpt_seed"},  dut.data_mem.dm1.DM[255], m_s0);
`else
    check8({tag, "_keep253"}, dut.data_mem.dm1.DM[253], img[253]);
    check8({tag, "_keep254"}, dut.data_mem.dm1.DM[254], img[254]);
    check8({tag, "_keep255"}, dut.data_mem.dm1.DM[255], img[255]);
`endif
  endtask

  // Directed / random sequence
  initial begin
    logic [7:0] init, t;
    int pre;

    reset = 1'b1;
    taps = '{8'hE1, 8'hD4, 8'hC6, 8'hB8, 8'hB4, 8'hB2, 8'hFA, 8'hF3};

    // Encrypt, basic
    set_msg("Mr. Watson, come here. I want to see you.");
    setup_enc(9, 8'hE1, 8'h41);
    run("enc_basic");
    check8("enc_b64", dut.data_mem.dm1.DM[64], 8'h61);
    check8("enc_b65", dut.data_mem.dm1.DM[65], 8'hA2);
    check8("enc_b66", dut.data_mem.dm1.DM[66], 8'h25);
    check8("enc_b73", dut.data_mem.dm1.DM[73], 8'h4D ^ m_ks[9]);
    push_model();
    check_out("enc_basic", 64);

    // Encrypt, longer preamble, message opening with two spaces
    set_msg("  ");
    for (int i = 2; i < 41; i++) msg_b[i] = 8'($urandom_range(33, 126));
    setup_enc(11, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
    run("enc_pre11");
    push_model();
    check_out("enc_pre11", 64);

    // Random encrypts across the legal preamble range
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 41; i++) msg_b[i] = 8'($urandom_range(32, 126));
      pre = $urandom_range(9, 23);
      setup_enc(pre, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
      run("enc_rand");
      push_model();
      check_out("enc_rand", 64);
    end

    // Decrypt with each tap pattern (B4 paired with seed 5A)
    for (int c = 0; c < 8; c++) begin
      init = (c == 4) ? 8'h5A : 8'($urandom_range(1, 255));
      set_msg("Knowledge comes, but wisdom lingers.     ");
      model_enc(9, taps[c], init);
      setup_dec();
      run("dec_know");
      model_dec();
      push_model();
      check_out("dec_know", 0);
      check_report("dec_know");
      if (m_tap == taps[c]) begin
        for (int i = 0; i < 41; i++) exp_q.push_back(msg_b[i]);
        for (int i = 41; i < 64; i++) exp_q.push_back(8'h20);
        check_out("dec_know_str", 0);
      end
    end

    // Decrypt with leading-space stripping
    t = taps[$urandom_range(0, 7)];
    set_msg("Ajok");
    model_enc(10, t, 8'($urandom_range(1, 255)));
    setup_dec();
    run("dec_ajok");
    model_dec();
    push_model();
    check_out("dec_ajok", 0);
    if (m_tap == t) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(msg_b[i]);
      for (int i = 4; i < 64; i++) exp_q.push_back(8'h20);
      check_out("dec_ajok_str", 0);
    end

    // Decrypt of an all-space frame, report area holds sentinels
    set_msg("");
    model_enc(9, taps[$urandom_range(0, 7)], 8'($urandom_range(1, 255)));
    setup_dec();
    for (int a = 253; a < 256; a++) img[a] = 8'($urandom_range(0, 255));
    run("dec_blank");
    model_dec();
    push_model();
    check_out("dec_blank", 0);
    check_report("dec_blank");

    // Decrypt of random ciphertext (usually the fallback tap)
    fill_zero();
    for (int i = 64; i < 128; i++) img[i] = 8'($urandom_range(0, 255));
    for (int a = 253; a < 256; a++) img[a] = 8'($urandom_range(0, 255));
    run("dec_noise");
    model_dec();
    push_model();
    check_out("dec_noise", 0);
    check_report("dec_noise");

    // Reset 100 cycles into an encrypt, then rerun on the same memory
    set_msg("Mr. Watson, come here. I want to see you.");
    setup_enc(9, 8'hE1, 8'h41);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_dut();
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check1("mid_rst_done", done, 1'b0);
    check_idle("mid_rst_state");
    reset = 1'b0;
    wait_done("mid_rst_rerun");
    push_model();
    check_out("mid_rst_rerun", 64);

    // done holds until reset, then drops on the reset edge
    repeat (5) @(negedge clk);
    check1("done_hold", done, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check1("post_done_rst", done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
